// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: prefix bytes, receiver FSM states and event-word layout.
package ps2_pkg;

    localparam int unsigned SCAN_W   = 8;
    localparam int unsigned EVT_W    = 10;
    localparam int unsigned BITCNT_W = 3;

    localparam logic [SCAN_W-1:0] PS2_EXT = 8'hE0;
    localparam logic [SCAN_W-1:0] PS2_BRK = 8'hF0;

    localparam int unsigned EXT_BIT = 9;
    localparam int unsigned BRK_BIT = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } ps2_state_e;

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronizes the PS/2 clock/data pins and strobes on each falling edge of the clock.
module ps2_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_sync,
    output logic fall
);

    logic [SYNC_STAGES-1:0] clk_sr;
    logic [SYNC_STAGES-1:0] dat_sr;
    logic                   clk_prev;

    // Chains reset to the idle-high line level so reset release never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sr    <= '1;
            dat_sr    <= '1;
            clk_prev  <= 1'b1;
            data_sync <= 1'b1;
            fall      <= 1'b0;
        end else begin
            clk_sr    <= {clk_sr[SYNC_STAGES-2:0], ps2_clk};
            dat_sr    <= {dat_sr[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sr[SYNC_STAGES-1];
            data_sync <= dat_sr[SYNC_STAGES-1];
            fall      <= clk_prev & ~clk_sr[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: deframes bytes and folds E0/F0 prefixes into {ext, brk, code} events.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 200_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic [EVT_W-1:0] data,
    output logic             ready,
    output logic             err
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic sdata;
    logic fall;

    ps2_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data_sync(sdata),
        .fall     (fall)
    );

    ps2_state_e           state,    state_n;
    logic [BITCNT_W-1:0]  bitcnt,   bitcnt_n;
    logic [SCAN_W-1:0]    shreg,    shreg_n;
    logic                 par,      par_n;
    logic                 ext_flag, ext_flag_n;
    logic                 brk_flag, brk_flag_n;
    logic [WD_W-1:0]      wdog,     wdog_n;
    logic [EVT_W-1:0]     data_n;
    logic                 ready_n;
    logic                 err_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            bitcnt   <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
            wdog     <= '0;
            data     <= '0;
            ready    <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            bitcnt   <= bitcnt_n;
            shreg    <= shreg_n;
            par      <= par_n;
            ext_flag <= ext_flag_n;
            brk_flag <= brk_flag_n;
            wdog     <= wdog_n;
            data     <= data_n;
            ready    <= ready_n;
            err      <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        bitcnt_n   = bitcnt;
        shreg_n    = shreg;
        par_n      = par;
        ext_flag_n = ext_flag;
        brk_flag_n = brk_flag;
        wdog_n     = wdog;
        data_n     = data;
        ready_n    = 1'b0;
        err_n      = 1'b0;

        // Watchdog only runs mid-frame; a fall always reloads it, even on the expiry cycle.
        if (fall) begin
            wdog_n = '0;
        end else if (state != S_IDLE) begin
            wdog_n = (wdog == WD_W'(TIMEOUT)) ? wdog : wdog + WD_W'(1);
        end

        if (fall) begin
            case (state)
                S_IDLE: begin
                    if (!sdata) begin
                        state_n  = S_DATA;
                        bitcnt_n = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                S_DATA: begin
                    shreg_n = {sdata, shreg[SCAN_W-1:1]};
                    if (bitcnt == BITCNT_W'(SCAN_W - 1)) begin
                        state_n = S_PARITY;
                    end else begin
                        bitcnt_n = bitcnt + BITCNT_W'(1);
                    end
                end
                S_PARITY: begin
                    par_n   = sdata;
                    state_n = S_STOP;
                end
                S_STOP: begin
                    state_n = S_IDLE;
                    if (sdata && (^{shreg, par})) begin
                        if (shreg == PS2_EXT) begin
                            ext_flag_n = 1'b1;
                        end else if (shreg == PS2_BRK) begin
                            brk_flag_n = 1'b1;
                        end else begin
                            data_n[EXT_BIT]      = ext_flag;
                            data_n[BRK_BIT]      = brk_flag;
                            data_n[SCAN_W-1:0]   = shreg;
                            ready_n              = 1'b1;
                            ext_flag_n           = 1'b0;
                            brk_flag_n           = 1'b0;
                        end
                    end else begin
                        err_n      = 1'b1;
                        ext_flag_n = 1'b0;
                        brk_flag_n = 1'b0;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end else if (state != S_IDLE && wdog == WD_W'(TIMEOUT)) begin
            state_n    = S_IDLE;
            bitcnt_n   = '0;
            ext_flag_n = 1'b0;
            brk_flag_n = 1'b0;
            wdog_n     = '0;
            err_n      = 1'b1;
        end
    end

endmodule

// File: doc/ps2_scan_rx.md
# ps2_scan_rx

Receives PS/2 keyboard frames from the board's `ps2_clk`/`ps2_data` pins and assembles them into complete key events for the scan-code-to-ASCII converter directly downstream. The `E0` (extended) and `F0` (break) prefix bytes are folded into flag bits. Each completed event is emitted as a 10-bit word `{ext, brk, code[7:0]}`, which the converter consumes unchanged.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops on each PS/2 input; minimum 2.
- `TIMEOUT`, default 200_000: `clk` cycles without a PS/2 falling edge before a partial frame is abandoned (2 ms at 100 MHz).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `ps2_clk`  in  1  raw PS/2 clock from pin; asynchronous.
- `ps2_data`  in  1  raw PS/2 data from pin; asynchronous.
- `data`  out  10  last key event: bit 9 = extended, bit 8 = break, bits 7:0 = scan code; held between events.
- `ready`  out  1  one-cycle pulse when `data` updates.
- `err`  out  1  one-cycle pulse on framing or parity failure.

## Operation
- Both pins pass through `SYNC_STAGES` flops. A falling edge of the synchronized `ps2_clk` generates the `fall` strobe; bits are sampled from synchronized `ps2_data` on `fall` only.
- Frame format: start 0, 8 data bits LSB first, odd parity, stop 1.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data = 0, go to DATA and clear `bitcnt`. On `fall` with data = 1, stay in IDLE and pulse `err`.
  - DATA: on each `fall`, shift the bit into `shreg[7]` (right shift). After 8 bits, go to PARITY.
  - PARITY: on `fall`, latch the parity bit, go to STOP.
  - STOP: on `fall`, return to IDLE. The frame is valid when stop = 1 and XOR(shreg, parity) = 1.
- Valid byte handling:
  - `E0`: set `ext_flag`.
  - `F0`: set `brk_flag`.
  - Any other byte: `data <= {ext_flag, brk_flag, byte}`, pulse `ready`, clear both flags.
- Invalid frame (bad parity or stop = 0): pulse `err`, clear both flags, leave `data` unchanged, no `ready`.
- Watchdog:
  - Counts `clk` cycles in any state other than IDLE and is reset on every `fall`.
  - On reaching `TIMEOUT`: go to IDLE, clear `bitcnt` and both flags, pulse `err`.
- Prefix flags persist across frames in IDLE, so `E0 F0 74` yields one event. A repeated prefix is idempotent.
- The block is receive-only and never drives the PS/2 lines.

## Timing
- Reset values: `data` = 10'h000, `ready` = 0, `err` = 0. FSM in IDLE, flags clear, all counters 0.
- Pin falling edge to `fall` strobe: `SYNC_STAGES` + 1 cycles (3 at default).
- `ready` and the new `data` assert together, one cycle after the `fall` that samples the stop bit.
- `err` asserts at the same point for a bad frame, or one cycle after the watchdog expires.
- `ready` and `err` never assert in the same cycle.
- `data` is stable from the `ready` cycle until the next `ready`.
- `rst_n` low mid-frame returns everything to reset values immediately. The partially received frame is discarded with no `ready` and no `err`.
- Watchdog expiry and `fall` in the same cycle: `fall` wins and the watchdog counter reloads.
- The watchdog counter saturates at `TIMEOUT`, with width `$clog2(TIMEOUT+1)`, and never wraps.

## Structure
- Shared package `ps2_pkg` holds:
  - `PS2_EXT` = 8'hE0 and `PS2_BRK` = 8'hF0;
  - the FSM state enum;
  - the event-word bit positions `EXT_BIT` = 9 and `BRK_BIT` = 8.
- One sub-module, `ps2_sync_edge`: the parameterized synchronizer plus falling-edge detector. It outputs synchronized data and the `fall` strobe, and is reusable for a future PS/2 mouse receiver.

## Test plan
- Frame `0x1C` (parity bit 0) at a 12.5 kHz PS/2 clock -> `ready` pulses once; `data` = 10'h01C.
- Frames `F0`, `1C` -> one `ready`, only after the second frame; `data` = 10'h11C.
- Frames `E0`, `74`, then `E0`, `F0`, `74` -> `data` = 10'h274, then 10'h374; exactly two `ready` pulses.
- Frame `0x1C` with parity bit 1 -> `err` pulses; no `ready`; `data` keeps its prior value. Then a good `0x29` -> `data` = 10'h029.
- Sequence `E0`, then 5 bits of the next frame, then an idle gap of `TIMEOUT`+10 cycles -> `err` pulses. A following `0x75` yields `data` = 10'h075 (ext cleared).
- `rst_n` asserted after 4 data bits -> outputs 0 immediately. After release, a full `0x5A` frame yields `data` = 10'h05A with a single `ready`.
